// File: rtl/spi_i2c_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// spi_i2c_cmd_ctrl : parses SPI command frames and sequences I2C START/ADDR/DATA/STOP.
// Optional response watchdog enabled by defining SPI_I2C_TIMEOUT_EN.
// Revision: 1.0
// ============================================================================
module spi_i2c_cmd_ctrl #(
    parameter int MAX_LEN     = 16,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic       wr_clk_i,
    input  logic       wr_rst_n_i,
    input  logic [7:0] rx_data_i,
    input  logic       rx_valid_i,
    input  logic       cs_n_sync_i,
    output logic       i2c_cmd_valid_o,
    input  logic       i2c_cmd_ready_i,
    output logic [1:0] i2c_cmd_o,
    output logic [7:0] i2c_wdata_o,
    output logic       i2c_last_o,
    input  logic       i2c_rsp_valid_i,
    input  logic [7:0] i2c_rsp_data_i,
    input  logic       i2c_rsp_ack_i,
    output logic [7:0] tx_data_o,
    output logic       tx_valid_o,
    output logic       busy_o,
    output logic       err_frame_o,
    output logic       err_nack_o,
    output logic       err_overrun_o,
    output logic       err_timeout_o
);

    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [1:0] c_cmd_start = 2'd0;
    localparam logic [1:0] c_cmd_write = 2'd1;
    localparam logic [1:0] c_cmd_read  = 2'd2;
    localparam logic [1:0] c_cmd_stop  = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE, S_HDR, S_LEN, S_COLLECT, S_START, S_ADDR, S_XFER, S_STOP
    } state_t;

    state_t          state_q;
    logic            cs_prev_q;
    logic [7:0]      addr_rw_q;
    logic [7:0]      len_q;
    logic [AW-1:0]   widx_q;
    logic [AW-1:0]   ridx_q;
    logic            wait_q;
    logic            cmd_valid_q;
    logic [1:0]      cmd_q;
    logic [7:0]      wdata_q;
    logic            last_q;
    logic [7:0]      tx_data_q;
    logic            tx_valid_q;
    logic            busy_q;
    logic            err_frame_q;
    logic            err_nack_q;
    logic            err_overrun_q;
    logic [7:0]      buf_q [MAX_LEN];

    logic            w_exec;
    logic            w_buf_we;
    logic            w_len_bad;
    logic            w_col_last;
    logic            w_xfer_last;
    logic            w_rsp;
    logic [AW-1:0]   w_ridx_nxt;

    assign w_exec      = (state_q == S_START) || (state_q == S_ADDR) ||
                         (state_q == S_XFER)  || (state_q == S_STOP);
    assign w_buf_we    = (state_q == S_COLLECT) && rx_valid_i;
    assign w_len_bad   = (rx_data_i == 8'd0) || (rx_data_i > 8'(MAX_LEN));
    assign w_col_last  = (8'(widx_q) == (len_q - 8'd1));
    assign w_xfer_last = (8'(ridx_q) == (len_q - 8'd1));
    assign w_rsp       = wait_q && i2c_rsp_valid_i;
    assign w_ridx_nxt  = ridx_q + AW'(1);

    always_ff @(posedge wr_clk_i) begin
        if (w_buf_we) begin
            buf_q[widx_q] <= rx_data_i;
        end
    end

`ifdef SPI_I2C_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] to_cnt_q;
    logic          err_timeout_q;
    assign err_timeout_o = err_timeout_q;
`else
    localparam int c_unused_timeout = TIMEOUT_CYC;
    assign err_timeout_o = 1'b0;
`endif

    always_ff @(posedge wr_clk_i or negedge wr_rst_n_i) begin
        if (!wr_rst_n_i) begin
            state_q       <= S_IDLE;
            cs_prev_q     <= 1'b1;
            addr_rw_q     <= 8'h00;
            len_q         <= 8'h00;
            widx_q        <= '0;
            ridx_q        <= '0;
            wait_q        <= 1'b0;
            cmd_valid_q   <= 1'b0;
            cmd_q         <= c_cmd_start;
            wdata_q       <= 8'h00;
            last_q        <= 1'b0;
            tx_data_q     <= 8'h00;
            tx_valid_q    <= 1'b0;
            busy_q        <= 1'b0;
            err_frame_q   <= 1'b0;
            err_nack_q    <= 1'b0;
            err_overrun_q <= 1'b0;
`ifdef SPI_I2C_TIMEOUT_EN
            to_cnt_q      <= '0;
            err_timeout_q <= 1'b0;
`endif
        end else begin
            cs_prev_q     <= cs_n_sync_i;
            tx_valid_q    <= 1'b0;
            err_frame_q   <= 1'b0;
            err_nack_q    <= 1'b0;
            err_overrun_q <= 1'b0;
`ifdef SPI_I2C_TIMEOUT_EN
            err_timeout_q <= 1'b0;
`endif
            if (cmd_valid_q && i2c_cmd_ready_i) begin
                cmd_valid_q <= 1'b0;
                wait_q      <= 1'b1;
            end
            if (w_exec && rx_valid_i) begin
                err_overrun_q <= 1'b1;
            end

            case (state_q)
                S_IDLE: begin
                    widx_q <= '0;
                    if (cs_prev_q && !cs_n_sync_i) begin
                        state_q <= S_HDR;
                        busy_q  <= 1'b1;
                    end else if (rx_valid_i && !cs_n_sync_i) begin
                        err_overrun_q <= 1'b1;
                    end
                end
                S_HDR: begin
                    if (cs_n_sync_i) begin
                        err_frame_q <= 1'b1;
                        state_q     <= S_IDLE;
                        busy_q      <= 1'b0;
                    end else if (rx_valid_i) begin
                        addr_rw_q <= rx_data_i;
                        state_q   <= S_LEN;
                    end
                end
                S_LEN: begin
                    // A read frame is complete with this byte, so a coincident cs_n rise is not an abort.
                    if (rx_valid_i && (w_len_bad || (cs_n_sync_i && !addr_rw_q[0]))) begin
                        err_frame_q <= 1'b1;
                        state_q     <= S_IDLE;
                        busy_q      <= 1'b0;
                    end else if (rx_valid_i && addr_rw_q[0]) begin
                        len_q       <= rx_data_i;
                        state_q     <= S_START;
                        cmd_valid_q <= 1'b1;
                        cmd_q       <= c_cmd_start;
                        wdata_q     <= 8'h00;
                        last_q      <= 1'b0;
                    end else if (rx_valid_i) begin
                        len_q   <= rx_data_i;
                        state_q <= S_COLLECT;
                    end else if (cs_n_sync_i) begin
                        err_frame_q <= 1'b1;
                        state_q     <= S_IDLE;
                        busy_q      <= 1'b0;
                    end
                end
                S_COLLECT: begin
                    if (rx_valid_i && w_col_last) begin
                        state_q     <= S_START;
                        cmd_valid_q <= 1'b1;
                        cmd_q       <= c_cmd_start;
                        wdata_q     <= 8'h00;
                        last_q      <= 1'b0;
                    end else if (cs_n_sync_i) begin
                        err_frame_q <= 1'b1;
                        state_q     <= S_IDLE;
                        busy_q      <= 1'b0;
                        widx_q      <= '0;
                    end else if (rx_valid_i) begin
                        widx_q <= widx_q + AW'(1);
                    end
                end
                S_START: begin
                    if (w_rsp) begin
                        wait_q      <= 1'b0;
                        state_q     <= S_ADDR;
                        cmd_valid_q <= 1'b1;
                        cmd_q       <= c_cmd_write;
                        wdata_q     <= addr_rw_q;
                    end
                end
                S_ADDR: begin
                    if (w_rsp) begin
                        wait_q      <= 1'b0;
                        cmd_valid_q <= 1'b1;
                        if (!i2c_rsp_ack_i) begin
                            err_nack_q <= 1'b1;
                            state_q    <= S_STOP;
                            cmd_q      <= c_cmd_stop;
                            wdata_q    <= 8'h00;
                        end else begin
                            state_q <= S_XFER;
                            ridx_q  <= '0;
                            if (addr_rw_q[0]) begin
                                cmd_q   <= c_cmd_read;
                                wdata_q <= 8'h00;
                                last_q  <= (len_q == 8'd1);
                            end else begin
                                cmd_q   <= c_cmd_write;
                                wdata_q <= buf_q[0];
                            end
                        end
                    end
                end
                S_XFER: begin
                    if (w_rsp) begin
                        wait_q      <= 1'b0;
                        cmd_valid_q <= 1'b1;
                        if (addr_rw_q[0]) begin
                            tx_data_q  <= i2c_rsp_data_i;
                            tx_valid_q <= 1'b1;
                        end
                        if ((!addr_rw_q[0] && !i2c_rsp_ack_i) || w_xfer_last) begin
                            err_nack_q <= !addr_rw_q[0] && !i2c_rsp_ack_i;
                            state_q    <= S_STOP;
                            cmd_q      <= c_cmd_stop;
                            wdata_q    <= 8'h00;
                            last_q     <= 1'b0;
                        end else begin
                            ridx_q  <= w_ridx_nxt;
                            wdata_q <= addr_rw_q[0] ? 8'h00 : buf_q[w_ridx_nxt];
                            last_q  <= addr_rw_q[0] && (8'(w_ridx_nxt) == (len_q - 8'd1));
                        end
                    end
                end
                S_STOP: begin
                    if (w_rsp) begin
                        wait_q  <= 1'b0;
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase

`ifdef SPI_I2C_TIMEOUT_EN
            // The master is unresponsive, so abandon the frame without issuing STOP.
            if (wait_q && !i2c_rsp_valid_i) begin
                if (to_cnt_q == TW'(TIMEOUT_CYC - 1)) begin
                    err_timeout_q <= 1'b1;
                    state_q       <= S_IDLE;
                    busy_q        <= 1'b0;
                    wait_q        <= 1'b0;
                    cmd_valid_q   <= 1'b0;
                    to_cnt_q      <= '0;
                end else begin
                    to_cnt_q <= to_cnt_q + TW'(1);
                end
            end else begin
                to_cnt_q <= '0;
            end
`endif
        end
    end

    assign i2c_cmd_valid_o = cmd_valid_q;
    assign i2c_cmd_o       = cmd_q;
    assign i2c_wdata_o     = wdata_q;
    assign i2c_last_o      = last_q;
    assign tx_data_o       = tx_data_q;
    assign tx_valid_o      = tx_valid_q;
    assign busy_o          = busy_q;
    assign err_frame_o     = err_frame_q;
    assign err_nack_o      = err_nack_q;
    assign err_overrun_o   = err_overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_i2c_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// tb_spi_i2c_cmd_ctrl : directed bench with a simple I2C master responder.
// Revision: 1.0
// ============================================================================
module tb_spi_i2c_cmd_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       cs_n = 1'b1;
    logic       ready = 1'b1;
    logic       rsp_valid = 1'b0;
    logic [7:0] rsp_data = 8'h00;
    logic       rsp_ack = 1'b0;

    logic       i2c_cmd_valid_o;
    logic [1:0] i2c_cmd_o;
    logic [7:0] i2c_wdata_o;
    logic       i2c_last_o;
    logic [7:0] tx_data_o;
    logic       tx_valid_o;
    logic       busy_o;
    logic       err_frame_o;
    logic       err_nack_o;
    logic       err_overrun_o;
    logic       err_timeout_o;

    spi_i2c_cmd_ctrl #(.MAX_LEN(16), .TIMEOUT_CYC(16)) dut (
        .wr_clk_i        (clk),
        .wr_rst_n_i      (rst_n),
        .rx_data_i       (rx_data),
        .rx_valid_i      (rx_valid),
        .cs_n_sync_i     (cs_n),
        .i2c_cmd_valid_o (i2c_cmd_valid_o),
        .i2c_cmd_ready_i (ready),
        .i2c_cmd_o       (i2c_cmd_o),
        .i2c_wdata_o     (i2c_wdata_o),
        .i2c_last_o      (i2c_last_o),
        .i2c_rsp_valid_i (rsp_valid),
        .i2c_rsp_data_i  (rsp_data),
        .i2c_rsp_ack_i   (rsp_ack),
        .tx_data_o       (tx_data_o),
        .tx_valid_o      (tx_valid_o),
        .busy_o          (busy_o),
        .err_frame_o     (err_frame_o),
        .err_nack_o      (err_nack_o),
        .err_overrun_o   (err_overrun_o),
        .err_timeout_o   (err_timeout_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int tests = 0;
    int fails = 0;

    // Responder controls, written only by the stimulus process.
    bit mute = 1'b0;
    int nack_at = -1;
    int rd_base = 0;

    // Responder/monitor state, written only by the responder process.
    logic [10:0] cmd_log[$];
    logic [7:0]  tx_log[$];
    int n_frame = 0, n_nack = 0, n_ovr = 0, n_to = 0, n_reads = 0, tx_late = 0;
    int pend = 0, p_idx = 0, hs_cyc = 0, to_cyc = 0;
    bit p_read = 1'b0, rsp_was_read = 1'b0;
    logic [7:0] p_data = 8'h00;

    always @(negedge clk) begin
        if (!rst_n) begin
            rsp_valid    = 1'b0;
            pend         = 0;
            rsp_was_read = 1'b0;
        end else begin
            n_frame += int'(err_frame_o);
            n_nack  += int'(err_nack_o);
            n_ovr   += int'(err_overrun_o);
            if (err_timeout_o) begin
                n_to++;
                to_cyc = cyc;
            end
            if (tx_valid_o) begin
                tx_log.push_back(tx_data_o);
                if (!rsp_was_read) tx_late++;
            end
            rsp_valid    = 1'b0;
            rsp_was_read = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    rsp_valid    = 1'b1;
                    rsp_ack      = (p_idx != nack_at);
                    rsp_data     = p_data;
                    rsp_was_read = p_read;
                end
            end
            if (i2c_cmd_valid_o && ready) begin
                cmd_log.push_back({i2c_cmd_o, i2c_last_o, i2c_wdata_o});
                hs_cyc = cyc;
                p_idx  = cmd_log.size() - 1;
                p_read = (i2c_cmd_o == 2'd2);
                p_data = 8'h00;
                if (p_read) begin
                    p_data = 8'h5A + 8'(17 * (n_reads - rd_base));
                    n_reads++;
                end
                if (!mute) pend = 2;
            end
        end
    end

    localparam logic [10:0] E_START = 11'h000;
    localparam logic [10:0] E_STOP  = 11'h600;

    function automatic logic [10:0] wr(input logic [7:0] b);
        return {2'd1, 1'b0, b};
    endfunction

    function automatic logic [10:0] rd(input logic l);
        return {2'd2, l, 8'h00};
    endfunction

    // Keeps only the fields that are meaningful for each command type.
    function automatic logic [10:0] norm(input logic [10:0] e);
        case (e[10:9])
            2'd1:    return {e[10:9], 1'b0, e[7:0]};
            2'd2:    return {e[10:9], e[8], 8'h00};
            default: return {e[10:9], 9'h000};
        endcase
    endfunction

    task automatic send(input logic [7:0] b, input bit raise_cs);
        repeat (2) @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        if (raise_cs) cs_n = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300; i++) begin
            if (!busy_o) break;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        tests++;
        if ({i2c_cmd_valid_o, i2c_cmd_o, i2c_wdata_o, i2c_last_o, tx_data_o, tx_valid_o,
             busy_o, err_frame_o, err_nack_o, err_overrun_o, err_timeout_o} !== 26'd0) begin
            fails++;
            $display("FAIL reset_outputs: got valid=%b cmd=%0d wdata=%h tx=%h busy=%b, required all 0",
                     i2c_cmd_valid_o, i2c_cmd_o, i2c_wdata_o, tx_data_o, busy_o);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_write();
        logic [10:0] exp[$];
        logic [10:0] got;
        int base = cmd_log.size();
        int e0 = n_frame + n_nack + n_ovr;
        exp.push_back(E_START); exp.push_back(wr(8'hA0)); exp.push_back(wr(8'h11));
        exp.push_back(wr(8'h22)); exp.push_back(E_STOP);
        @(negedge clk) cs_n = 1'b0;
        @(negedge clk);
        tests++;
        if (busy_o !== 1'b1) begin
            fails++; $display("FAIL write_busy_rise: got %b required 1", busy_o);
        end
        send(8'hA0, 0); send(8'h02, 0); send(8'h11, 0); send(8'h22, 0);
        tests++;
        if ({i2c_cmd_valid_o, i2c_cmd_o} !== 3'b100) begin
            fails++; $display("FAIL write_start_latency: got valid=%b cmd=%0d required valid=1 cmd=0",
                              i2c_cmd_valid_o, i2c_cmd_o);
        end
        wait_idle();
        tests++;
        if (busy_o !== 1'b0) begin
            fails++; $display("FAIL write_busy_fall: got %b required 0", busy_o);
        end
        tests++;
        if (cmd_log.size() - base != exp.size()) begin
            fails++; $display("FAIL write_cmd_count: got %0d required %0d", cmd_log.size() - base, exp.size());
        end
        for (int i = 0; i < exp.size(); i++) begin
            got = (base + i < cmd_log.size()) ? norm(cmd_log[base + i]) : 11'h7FF;
            tests++;
            if (got !== exp[i]) begin
                fails++; $display("FAIL write_cmd[%0d]: got %h required %h", i, got, exp[i]);
            end
        end
        tests++;
        if (n_frame + n_nack + n_ovr - e0 != 0) begin
            fails++; $display("FAIL write_errors: got %0d pulses required 0", n_frame + n_nack + n_ovr - e0);
        end
        @(negedge clk) cs_n = 1'b1;
    endtask

    task automatic test_read(input bit inject);
        logic [10:0] exp[$];
        logic [7:0]  exp_tx[$];
        logic [10:0] got;
        int base = cmd_log.size();
        int tbase = tx_log.size();
        int o0 = n_ovr;
        int l0 = tx_late;
        int len = inject ? 2 : 3;
        rd_base = n_reads;
        exp.push_back(E_START); exp.push_back(wr(8'hA1));
        for (int i = 0; i < len; i++) exp.push_back(rd(i == len - 1));
        exp.push_back(E_STOP);
        exp_tx.push_back(8'h5A); exp_tx.push_back(8'h6B);
        if (!inject) exp_tx.push_back(8'h7C);
        @(negedge clk) cs_n = 1'b0;
        send(8'hA1, 0); send(8'(len), 0);
        if (inject) begin
            for (int i = 0; i < 100; i++) begin
                if (cmd_log.size() >= base + 3) break;
                @(negedge clk);
            end
            send(8'h33, 0);
        end
        wait_idle();
        tests++;
        if (cmd_log.size() - base != exp.size()) begin
            fails++; $display("FAIL read_cmd_count: got %0d required %0d", cmd_log.size() - base, exp.size());
        end
        for (int i = 0; i < exp.size(); i++) begin
            got = (base + i < cmd_log.size()) ? norm(cmd_log[base + i]) : 11'h7FF;
            tests++;
            if (got !== exp[i]) begin
                fails++; $display("FAIL read_cmd[%0d]: got %h required %h", i, got, exp[i]);
            end
        end
        for (int i = 0; i < exp_tx.size(); i++) begin
            tests++;
            if (tbase + i >= tx_log.size() || tx_log[tbase + i] !== exp_tx[i]) begin
                fails++; $display("FAIL read_tx[%0d]: got %h required %h", i,
                                  (tbase + i < tx_log.size()) ? tx_log[tbase + i] : 8'hxx, exp_tx[i]);
            end
        end
        tests++;
        if (tx_log.size() - tbase != exp_tx.size() || tx_late != l0) begin
            fails++; $display("FAIL read_tx_timing: got %0d bytes %0d misaligned required %0d bytes 0 misaligned",
                              tx_log.size() - tbase, tx_late - l0, exp_tx.size());
        end
        tests++;
        if (n_ovr - o0 != (inject ? 1 : 0)) begin
            fails++; $display("FAIL read_overrun: got %0d pulses required %0d", n_ovr - o0, inject ? 1 : 0);
        end
        @(negedge clk) cs_n = 1'b1;
    endtask

    task automatic test_nack();
        logic [10:0] exp[$];
        logic [10:0] got;
        int base = cmd_log.size();
        int n0 = n_nack;
        exp.push_back(E_START); exp.push_back(wr(8'h90)); exp.push_back(E_STOP);
        nack_at = base + 1;
        @(negedge clk) cs_n = 1'b0;
        send(8'h90, 0); send(8'h01, 0); send(8'hFF, 0);
        wait_idle();
        tests++;
        if (cmd_log.size() - base != exp.size() || n_nack - n0 != 1) begin
            fails++; $display("FAIL nack_count: got %0d cmds %0d nacks required 3 cmds 1 nack",
                              cmd_log.size() - base, n_nack - n0);
        end
        for (int i = 0; i < exp.size(); i++) begin
            got = (base + i < cmd_log.size()) ? norm(cmd_log[base + i]) : 11'h7FF;
            tests++;
            if (got !== exp[i]) begin
                fails++; $display("FAIL nack_cmd[%0d]: got %h required %h", i, got, exp[i]);
            end
        end
        nack_at = -1;
        @(negedge clk) cs_n = 1'b1;
    endtask

    // Frames that must abort: len 0, len above MAX_LEN, and cs_n rising after two of four data bytes.
    task automatic test_frame_errors();
        logic [7:0] lens [3] = '{8'h00, 8'h11, 8'h04};
        for (int k = 0; k < 3; k++) begin
            int base = cmd_log.size();
            int f0 = n_frame;
            @(negedge clk) cs_n = 1'b0;
            send(8'h50, 0); send(lens[k], 0);
            if (k == 2) begin
                send(8'hDE, 0); send(8'hAD, 0);
                @(negedge clk) cs_n = 1'b1;
            end
            repeat (6) @(negedge clk);
            tests++;
            if (n_frame - f0 != 1 || cmd_log.size() != base || busy_o !== 1'b0) begin
                fails++; $display("FAIL frame_err[%0d]: got %0d pulses %0d cmds busy=%b required 1 pulse 0 cmds busy=0",
                                  k, n_frame - f0, cmd_log.size() - base, busy_o);
            end
            @(negedge clk) cs_n = 1'b1;
        end
    endtask

    task automatic test_cs_with_last_byte();
        logic [10:0] exp[$];
        logic [10:0] got;
        int base = cmd_log.size();
        int f0 = n_frame;
        exp.push_back(E_START); exp.push_back(wr(8'h42)); exp.push_back(wr(8'h77)); exp.push_back(E_STOP);
        @(negedge clk) cs_n = 1'b0;
        send(8'h42, 0); send(8'h01, 0); send(8'h77, 1);
        wait_idle();
        tests++;
        if (n_frame != f0 || cmd_log.size() - base != exp.size()) begin
            fails++; $display("FAIL cs_last_count: got %0d frame errs %0d cmds required 0 and 4",
                              n_frame - f0, cmd_log.size() - base);
        end
        for (int i = 0; i < exp.size(); i++) begin
            got = (base + i < cmd_log.size()) ? norm(cmd_log[base + i]) : 11'h7FF;
            tests++;
            if (got !== exp[i]) begin
                fails++; $display("FAIL cs_last_cmd[%0d]: got %h required %h", i, got, exp[i]);
            end
        end
    endtask

    task automatic test_timeout();
        int base = cmd_log.size();
        int t0 = n_to;
        mute = 1'b1;
        @(negedge clk) cs_n = 1'b0;
        send(8'hA1, 0); send(8'h01, 0);
`ifdef SPI_I2C_TIMEOUT_EN
        for (int i = 0; i < 60; i++) begin
            if (n_to != t0) break;
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        tests++;
        if (n_to - t0 != 1 || (to_cyc - hs_cyc - 1) != 16) begin
            fails++; $display("FAIL timeout_pulse: got %0d pulses at %0d cycles required 1 at 16",
                              n_to - t0, to_cyc - hs_cyc - 1);
        end
        tests++;
        if (busy_o !== 1'b0 || cmd_log.size() - base != 1) begin
            fails++; $display("FAIL timeout_idle: got busy=%b cmds=%0d required busy=0 cmds=1",
                              busy_o, cmd_log.size() - base);
        end
`else
        repeat (40) @(negedge clk);
        tests++;
        if (busy_o !== 1'b1 || n_to != t0 || cmd_log.size() - base != 1) begin
            fails++; $display("FAIL no_watchdog: got busy=%b timeouts=%0d cmds=%0d required busy=1 0 1",
                              busy_o, n_to - t0, cmd_log.size() - base);
        end
        rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
`endif
        @(negedge clk) cs_n = 1'b1;
        mute = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int base = cmd_log.size();
        mute = 1'b1;
        @(negedge clk) cs_n = 1'b0;
        send(8'hA1, 0); send(8'h01, 0);
        repeat (8) @(negedge clk);
        tests++;
        if (busy_o !== 1'b1 || cmd_log.size() - base != 1) begin
            fails++; $display("FAIL rstmid_pre: got busy=%b cmds=%0d required busy=1 cmds=1",
                              busy_o, cmd_log.size() - base);
        end
        rst_n = 1'b0;
        #1;
        tests++;
        if (busy_o !== 1'b0 || i2c_cmd_valid_o !== 1'b0) begin
            fails++; $display("FAIL rstmid_async: got busy=%b valid=%b required 0 0", busy_o, i2c_cmd_valid_o);
        end
        @(negedge clk);
        cs_n  = 1'b1;
        rst_n = 1'b1;
        mute  = 1'b0;
        repeat (6) @(negedge clk);
        tests++;
        if (cmd_log.size() - base != 1 || busy_o !== 1'b0) begin
            fails++; $display("FAIL rstmid_no_stop: got cmds=%0d busy=%b required cmds=1 busy=0",
                              cmd_log.size() - base, busy_o);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read(1'b0);
        test_nack();
        test_frame_errors();
        test_read(1'b1);
        test_cs_with_last_byte();
        test_timeout();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL sim_time_limit: got no finish by 500000, required finish earlier");
        $fatal(1, "time limit");
    end

endmodule
`default_nettype wire

// File: doc/spi_i2c_cmd_ctrl.md
# spi_i2c_cmd_ctrl

Command sequencer for the SPI-to-I2C bridge. It consumes bytes received by the SPI slave in the `wr_clk` domain and parses them into a command frame. Write payloads are buffered, and the frame is executed as a START / ADDR / DATA / STOP sequence on the I2C master command interface. Read data is returned as a byte stream for the SPI response path.

## Interface
Parameters:
- `MAX_LEN`, default 16: maximum payload bytes per frame; also the depth of the write buffer.
- `TIMEOUT_CYC`, default 1024: response watchdog limit in `wr_clk` cycles. Used only with `SPI_I2C_TIMEOUT_EN`.

Ports:
- `wr_clk` in 1: single clock; all logic is in this domain.
- `wr_rst_n` in 1: reset; asynchronous assert, active-low.
- `rx_data` in 8: received SPI byte.
- `rx_valid` in 1: one-cycle strobe qualifying `rx_data` (the spi_slave `wr_en`).
- `cs_n_sync` in 1: chip select, already synchronised to `wr_clk`; high means no frame is in progress.
- `i2c_cmd_valid` out 1: command request.
- `i2c_cmd_ready` in 1: master accepts the command.
- `i2c_cmd` out 2: 0 = START, 1 = WRITE, 2 = READ, 3 = STOP.
- `i2c_wdata` out 8: byte to send for WRITE.
- `i2c_last` out 1: on READ, master NACKs this byte.
- `i2c_rsp_valid` in 1: one-cycle command-completion strobe, returned for every command.
- `i2c_rsp_data` in 8: read byte, valid with a READ response.
- `i2c_rsp_ack` in 1: target ACK, valid with a WRITE response.
- `tx_data` out 8, `tx_valid` out 1: read byte to the response path; one-cycle strobe.
- `busy` out 1: high in every state except IDLE.
- `err_frame`, `err_nack`, `err_overrun`, `err_timeout` out 1 each: one-cycle error pulses.

## Operation
Frame format:
- Byte 0 is `{addr[6:0], rw}`, with rw = 1 for read.
- Byte 1 is `len`.
- For a write, `len` data bytes follow.

State machine states: IDLE, HDR, LEN, COLLECT, START, ADDR, XFER, STOP.
- IDLE → HDR when `cs_n_sync` falls.
- HDR captures byte 0 and moves to LEN.
- LEN captures `len`:
  - `len` == 0 or `len` > `MAX_LEN`: pulse `err_frame`, return to IDLE.
  - Read frame: go to START.
  - Write frame: go to COLLECT.
- COLLECT writes each byte into the buffer; after byte `len` is stored, go to START.
- START issues START. ADDR issues WRITE with `i2c_wdata` = `{addr, rw}`.
- XFER:
  - Write: issues WRITE for each buffered byte in arrival order.
  - Read: issues READ `len` times, with `i2c_last` = 1 on the final READ only; each `i2c_rsp_data` is forwarded to `tx_data`.
- STOP issues STOP, then goes to IDLE. It is not gated on `cs_n_sync`.

Command handshake:
- `i2c_cmd_valid`, `i2c_cmd`, `i2c_wdata` and `i2c_last` are held stable until `valid && ready`.
- After the handshake, the FSM waits for `i2c_rsp_valid` before issuing the next command. Only one command is ever outstanding.

Boundary conditions:
- **NACK:** a WRITE response with `i2c_rsp_ack` = 0 (address or data) pulses `err_nack`, skips the remaining bytes and goes to STOP.
- **cs_n rises early:** if `cs_n_sync` rises in HDR, LEN or COLLECT before the frame is complete, pulse `err_frame`, flush the buffer, return to IDLE, and issue no I2C commands.
- **Bytes while executing:** an `rx_valid` in START, ADDR, XFER or STOP drops the byte and pulses `err_overrun`.
- **Extra bytes:** bytes beyond `len` in the same frame are treated the same as bytes while executing.
- **Buffer indexing:** the buffer read/write index is `$clog2(MAX_LEN)` bits wide. The write index resets to 0 in IDLE, so it never wraps.
- **Reset mid-transaction:** the FSM returns to IDLE immediately and no STOP is issued. Bus recovery belongs to the I2C master.

## Timing
- **Reset values:** every output is 0, including `i2c_cmd` = 0 and `tx_data` = 0x00.
- **Registered outputs:** all outputs are registered.
- **Command issue latency:** the `rx_valid` that completes the frame is at cycle N; START `i2c_cmd_valid` goes high at N+1.
- **Between commands:** `i2c_rsp_valid` at cycle M gives the next `i2c_cmd_valid` at M+1.
- **Read data:** `tx_valid`/`tx_data` appear at M+1 after a READ `i2c_rsp_valid` at M.
- **Error pulses:** each error pulse is exactly 1 cycle, asserted the cycle after the detecting event.
- **`busy` rise:** `busy` rises the cycle after `cs_n_sync` falls.
- **`busy` fall:** `busy` falls the cycle after the STOP response, or the cycle after an abort.
- **Simultaneous `cs_n_sync` rise and final `rx_valid`:** the byte is accepted and the frame completes; no `err_frame`.

## Configuration
- `SPI_I2C_TIMEOUT_EN` defined:
  - A counter runs while the FSM waits for `i2c_rsp_valid`, and clears on every response.
  - When the counter reaches `TIMEOUT_CYC`, pulse `err_timeout` and go directly to IDLE. Issue no STOP, since the master is unresponsive.
- `SPI_I2C_TIMEOUT_EN` undefined: no counter is built, `err_timeout` is tied to 0, and the FSM waits indefinitely.

## Test plan
- **Write frame:** bytes 0xA0, 0x02, 0x11, 0x22 with the master always ready and ACKing → commands START, WRITE 0xA0, WRITE 0x11, WRITE 0x22, STOP in that order; no errors; `busy` low after the STOP response.
- **Read frame:** bytes 0xA1, 0x03; master returns 0x5A, 0x6B, 0x7C → three READ commands with `i2c_last` = 0, 0, 1; `tx_valid` pulses carrying 0x5A, 0x6B, 0x7C.
- **Address NACK:** bytes 0x90, 0x01, 0xFF; ADDR response has `i2c_rsp_ack` = 0 → one `err_nack` pulse, next command is STOP, and 0xFF is never sent.
- **Bad length and early cs_n:**
  - `len` = 0x00 → one `err_frame` pulse and no I2C commands.
  - Write frame with `len` = 4 and `cs_n_sync` rising after 2 data bytes → one `err_frame` pulse and no I2C commands.
- **Overrun:** an `rx_valid` with 0x33 during XFER → one `err_overrun` pulse; the transfer completes unchanged.
- **Timeout (`SPI_I2C_TIMEOUT_EN` defined, `TIMEOUT_CYC` = 16):** START is accepted but no response arrives → `err_timeout` pulses 16 cycles after the handshake; FSM returns to IDLE.
